// File: rtl/calc_sequencer.sv
// Multi-cycle command sequencer for the 8-register calculator: LOADI, ALU, ITER and READ.
// Optional CALC_SEQ_CARRY_STOP_EN: an ITER command stops after the first WB that follows a carry.
module calc_sequencer #(
    parameter int unsigned CNT_W     = 4,
    parameter logic [3:0]  PASS_FUNC = 4'd0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_func,
    input  logic [2:0]       cmd_rd,
    input  logic [2:0]       cmd_rs,
    input  logic [7:0]       cmd_imm,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic             calc_WEN,
    output logic [2:0]       calc_RW,
    output logic [2:0]       calc_RX,
    output logic [2:0]       calc_RY,
    output logic [7:0]       calc_DataIn,
    output logic             calc_Sel,
    output logic [3:0]       calc_Ctrl,
    input  logic [7:0]       calc_busY,
    input  logic             calc_Carry,
    output logic             done,
    output logic [7:0]       result,
    output logic             carry_out,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, WB, DONE} state_t;

    localparam logic [1:0] OP_LOADI = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_ITER  = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    state_t             state, state_d;
    logic [1:0]         op_q, op_d;
    logic [3:0]         func_q, func_d;
    logic [2:0]         rd_q, rd_d;
    logic [2:0]         rs_q, rs_d;
    logic [7:0]         imm_q, imm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         result_d;
    logic               carry_d;

    logic               wen_d, sel_d;
    logic [2:0]         rw_d, rxy_d;
    logic [7:0]         din_d;
    logic [3:0]         ctrl_d;

    // Next-state, command latch and capture logic
    always_comb begin
        state_d  = state;
        op_d     = op_q;
        func_d   = func_q;
        rd_d     = rd_q;
        rs_d     = rs_q;
        imm_d    = imm_q;
        cnt_d    = cnt_q;
        result_d = result;
        carry_d  = carry_out;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    func_d = cmd_func;
                    rd_d   = cmd_rd;
                    rs_d   = cmd_rs;
                    imm_d  = cmd_imm;
                    cnt_d  = cmd_cnt;
                    case (cmd_op)
                        OP_LOADI: begin
                            result_d = cmd_imm;
                            carry_d  = 1'b0;
                            state_d  = WB;
                        end
                        OP_ITER: begin
                            if (cmd_cnt == '0) begin
                                state_d = DONE;
                            end else begin
                                carry_d = 1'b0;
                                state_d = EXEC;
                            end
                        end
                        default: state_d = EXEC;
                    endcase
                end
            end
            EXEC: begin
                result_d = calc_busY;
                carry_d  = (op_q == OP_ITER) ? (carry_out | calc_Carry) : calc_Carry;
                state_d  = (op_q == OP_READ) ? DONE : WB;
            end
            WB: begin
                if (op_q == OP_ITER) begin
                    cnt_d = cnt_q - CNT_W'(1);
`ifdef CALC_SEQ_CARRY_STOP_EN
                    // carry_out was cleared at accept, so it is set only by this run's carries
                    state_d = ((cnt_d == '0) || carry_out) ? DONE : EXEC;
`else
                    state_d = (cnt_d == '0) ? DONE : EXEC;
`endif
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Calculator port values for the upcoming state, registered below
    always_comb begin
        wen_d  = 1'b0;
        sel_d  = 1'b0;
        rw_d   = 3'd0;
        rxy_d  = 3'd0;
        din_d  = 8'd0;
        ctrl_d = 4'd0;
        case (state_d)
            EXEC: begin
                sel_d  = 1'b1;
                ctrl_d = func_d;
                din_d  = imm_d;
                rxy_d  = (op_d == OP_ITER) ? rd_d : rs_d;
                if (op_d == OP_READ) begin
                    ctrl_d = PASS_FUNC;
                    din_d  = 8'd0;
                end
            end
            WB: begin
                wen_d = 1'b1;
                rw_d  = rd_d;
                din_d = result_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            op_q        <= 2'd0;
            func_q      <= 4'd0;
            rd_q        <= 3'd0;
            rs_q        <= 3'd0;
            imm_q       <= 8'd0;
            cnt_q       <= '0;
            result      <= 8'd0;
            carry_out   <= 1'b0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            calc_WEN    <= 1'b0;
            calc_RW     <= 3'd0;
            calc_RX     <= 3'd0;
            calc_RY     <= 3'd0;
            calc_DataIn <= 8'd0;
            calc_Sel    <= 1'b0;
            calc_Ctrl   <= 4'd0;
        end else begin
            state       <= state_d;
            op_q        <= op_d;
            func_q      <= func_d;
            rd_q        <= rd_d;
            rs_q        <= rs_d;
            imm_q       <= imm_d;
            cnt_q       <= cnt_d;
            result      <= result_d;
            carry_out   <= carry_d;
            cmd_ready   <= (state_d == IDLE);
            busy        <= (state_d != IDLE);
            done        <= (state_d == DONE);
            calc_WEN    <= wen_d;
            calc_RW     <= rw_d;
            calc_RX     <= rxy_d;
            calc_RY     <= rxy_d;
            calc_DataIn <= din_d;
            calc_Sel    <= sel_d;
            calc_Ctrl   <= ctrl_d;
        end
    end

endmodule
